// File: rtl/note_arbiter_if.sv
// Key-event / note-output bundle between the debouncers, the note arbiter and the tone generator.
interface note_arbiter_if #(
    parameter int unsigned TONE_W = 20
);
    logic [7:0]        key_flag;
    logic [7:0]        key_value;
    logic              note_valid;
    logic [2:0]        note_idx;
    logic              note_start;
    logic [TONE_W-1:0] tone_div;
    logic [7:0]        held_mask;

    modport master (
        output key_flag, key_value,
        input  note_valid, note_idx, note_start, tone_div, held_mask
    );

    modport slave (
        input  key_flag, key_value,
        output note_valid, note_idx, note_start, tone_div, held_mask
    );
endinterface

// File: rtl/note_arbiter.sv
// Monophonic last-pressed-wins note arbiter for the 8-key piano.
// Define NOTE_ARB_RELEASE_EN to build in the RELEASE tail state and its 24-bit counter.
module note_arbiter #(
    parameter int unsigned RELEASE_CYC = 4_800_000,
    parameter int unsigned TONE_W      = 20
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    note_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

    localparam logic [23:0] REL_LOAD = 24'(RELEASE_CYC - 1);

    state_t            state, state_n;
    logic [2:0]        idx_q, idx_n;
    logic              start_q, start_n;
    logic [TONE_W-1:0] tone_q;
    logic [7:0]        held_q, held_n;
    logic [7:0]        press, rel;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [TONE_W-1:0] tone_lut(input logic [2:0] i);
        logic [TONE_W-1:0] t;
        unique case (i)
            3'd0:    t = TONE_W'(91732);
            3'd1:    t = TONE_W'(81727);
            3'd2:    t = TONE_W'(72810);
            3'd3:    t = TONE_W'(68722);
            3'd4:    t = TONE_W'(61224);
            3'd5:    t = TONE_W'(54545);
            3'd6:    t = TONE_W'(48595);
            default: t = TONE_W'(45867);
        endcase
        return t;
    endfunction

    // Flags whose level matches the held bit are redundant and dropped here
    assign press  = bus.key_flag & ~bus.key_value & ~held_q;
    assign rel    = bus.key_flag &  bus.key_value &  held_q;
    assign held_n = (held_q | press) & ~rel;

`ifdef NOTE_ARB_RELEASE_EN
    logic [23:0] cnt_q, cnt_n;
`else
    logic unused_rel;
    assign unused_rel = ^REL_LOAD;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        start_n = 1'b0;
`ifdef NOTE_ARB_RELEASE_EN
        cnt_n   = cnt_q;
`endif
        unique case (state)
            IDLE: begin
                if (|press) begin
                    state_n = PLAY;
                    idx_n   = lowest(press);
                    start_n = 1'b1;
                end
            end
            PLAY: begin
                if (|press) begin
                    idx_n   = lowest(press);
                    start_n = (idx_n != idx_q);
                end else if (rel[idx_q]) begin
                    if (|held_n) begin
                        idx_n   = lowest(held_n);
                        start_n = 1'b1;
                    end else begin
`ifdef NOTE_ARB_RELEASE_EN
                        state_n = RELEASE;
                        cnt_n   = REL_LOAD;
`else
                        state_n = IDLE;
`endif
                    end
                end
            end
`ifdef NOTE_ARB_RELEASE_EN
            RELEASE: begin
                if (|press) begin
                    state_n = PLAY;
                    idx_n   = lowest(press);
                    start_n = (idx_n != idx_q);
                end else if (cnt_q == 24'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - 24'd1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            idx_q   <= 3'd0;
            start_q <= 1'b0;
            tone_q  <= '0;
            held_q  <= 8'h00;
        end else begin
            state   <= state_n;
            idx_q   <= idx_n;
            start_q <= start_n;
            tone_q  <= (state_n != IDLE) ? tone_lut(idx_n) : '0;
            held_q  <= held_n;
        end
    end

`ifdef NOTE_ARB_RELEASE_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) cnt_q <= 24'd0;
        else         cnt_q <= cnt_n;
    end
`endif

    assign bus.note_valid = (state != IDLE);
    assign bus.note_idx   = idx_q;
    assign bus.note_start = start_q;
    assign bus.tone_div   = tone_q;
    assign bus.held_mask  = held_q;

endmodule

// File: tb/tb_note_arbiter.sv
// Directed plus random bench for note_arbiter against a key-list reference model.
// Follows NOTE_ARB_RELEASE_EN the same way the design does.
module tb_note_arbiter;

    localparam int REL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    note_arbiter_if #(.TONE_W(20)) bus ();

    note_arbiter #(.RELEASE_CYC(REL), .TONE_W(20)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned tones [8] = '{91732, 81727, 72810, 68722, 61224, 54545, 48595, 45867};

    logic [7:0] m_held;
    bit         m_valid;
    int         m_idx;
    int         m_tail;
    bit         m_start;

    task automatic model_reset();
        m_held  = 8'h00;
        m_valid = 0;
        m_idx   = 0;
        m_tail  = -1;
        m_start = 0;
    endtask

    task automatic model(input logic [7:0] f, input logic [7:0] v);
        int lo_p;
        bit rel_cur;
        lo_p    = -1;
        rel_cur = 0;
        m_start = 0;
        for (int i = 0; i < 8; i++) begin
            if (f[i] && !v[i] && !m_held[i]) begin
                if (lo_p < 0) lo_p = i;
                m_held[i] = 1'b1;
            end else if (f[i] && v[i] && m_held[i]) begin
                m_held[i] = 1'b0;
                if (m_valid && m_tail < 0 && i == m_idx) rel_cur = 1;
            end
        end
        if (lo_p >= 0) begin
            m_start = !m_valid || (lo_p != m_idx);
            m_valid = 1;
            m_idx   = lo_p;
            m_tail  = -1;
        end else if (m_tail > 0) begin
            m_tail--;
            if (m_tail == 0) begin
                m_valid = 0;
                m_tail  = -1;
            end
        end else if (rel_cur) begin
            if (m_held != 8'h00) begin
                for (int i = 7; i >= 0; i--) if (m_held[i]) m_idx = i;
                m_start = 1;
            end else begin
`ifdef NOTE_ARB_RELEASE_EN
                m_tail = REL;
`else
                m_valid = 0;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [2:0] ei;
        ei = 3'(m_idx);
        chk("note_valid", 32'(bus.note_valid), 32'(m_valid));
        chk("note_idx",   32'(bus.note_idx),   32'(ei));
        chk("note_start", 32'(bus.note_start), 32'(m_start));
        chk("tone_div",   32'(bus.tone_div),   m_valid ? tones[m_idx] : 32'd0);
        chk("held_mask",  32'(bus.held_mask),  32'(m_held));
    endtask

    task automatic step(input logic [7:0] f, input logic [7:0] v);
        @(negedge clk);
        bus.key_flag  = f;
        bus.key_value = v;
        model(f, v);
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'h00, 8'h00);
    endtask

    initial begin
        bus.key_flag  = 8'h00;
        bus.key_value = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all();
        @(negedge clk);
        rst = 1'b0;

        step(8'h08, 8'h00);
        chk("press3_tone", 32'(bus.tone_div), 32'd68722);
        chk("press3_start", 32'(bus.note_start), 32'd1);
        idle(1);
        chk("start_one_cycle", 32'(bus.note_start), 32'd0);
        step(8'h40, 8'h00);
        chk("press6_idx", 32'(bus.note_idx), 32'd6);
        step(8'h40, 8'h40);
        chk("rel6_idx", 32'(bus.note_idx), 32'd3);
        chk("rel6_held", 32'(bus.held_mask), 32'h08);

        step(8'h08, 8'h08);
        idle(REL + 2);
        chk("tail_done_valid", 32'(bus.note_valid), 32'd0);

        step(8'h24, 8'h00);
        chk("dual_press_idx", 32'(bus.note_idx), 32'd2);
        step(8'h04, 8'h00);
        chk("redundant_start", 32'(bus.note_start), 32'd0);
        step(8'h24, 8'h24);
        idle(9);
        step(8'h80, 8'h00);
        chk("repress7_idx", 32'(bus.note_idx), 32'd7);
        step(8'h80, 8'h80);
        idle(4);
        step(8'h80, 8'h00);
        step(8'h80, 8'h80);
        idle(REL + 2);

        step(8'h20, 8'h00);
        step(8'h01, 8'h00);
        chk("pre_reset_held", 32'(bus.held_mask), 32'h21);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst = 1'b0;
        bus.key_flag = 8'h00;
        step(8'h01, 8'h00);
        chk("post_reset_tone", 32'(bus.tone_div), 32'd91732);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) idle($urandom_range(1, REL + 4));
            else step(8'($urandom & $urandom & $urandom), 8'($urandom));
        end

        @(negedge clk);
        bus.key_flag = 8'h00;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
